instr_fetch_unit: RTL and testbench

//   Supplies 16-bit instruction words to the instruction handler, one at a time.

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 88 ++++++++
 tb/tb_instr_fetch_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Handshake bundle between the fetch unit, program memory and the instruction handler.
// The master side is the fetch unit; the slave side is the memory/handler environment.
interface instr_fetch_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        jump;
    logic [15:0] jump_target;
    logic        halt;
    logic [15:0] pc;
    logic        halted;
    logic        fetch_err;

    modport master (
        output mem_req, mem_addr, instr, instr_valid, pc, halted, fetch_err,
        input  mem_ack, mem_rdata, exec_done, jump, jump_target, halt
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_valid, pc, halted, fetch_err,
        output mem_ack, mem_rdata, exec_done, jump, jump_target, halt
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter plus fetch sequencer: requests one instruction word, holds it
// for the handler until it is executed, then steps or jumps the PC.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);
    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_HALTED, S_ERROR
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     pc_q, pc_d;
    logic [W-1:0]     instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, instr_valid_q, halted_q, fetch_err_q;
    logic             timeout_hit;

    // Timeout fires on the last stalled cycle; TIMEOUT=0 disables it.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = '0;
        unique case (state_q)
            S_IDLE: state_d = bus.halt ? S_HALTED : S_FETCH;
            S_FETCH: begin
                if (bus.mem_ack) begin
                    instr_d = bus.mem_rdata;
                    state_d = S_EXEC;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    // Only control words (bit 15 set) may redirect the PC.
                    pc_d    = (instr_q[15] && bus.jump) ? bus.jump_target : pc_q + W'(1);
                    state_d = bus.halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: state_d = S_HALTED;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= (state_d == S_FETCH);
            instr_valid_q <= (state_d == S_EXEC);
            halted_q      <= (state_d == S_HALTED);
            fetch_err_q   <= (state_d == S_ERROR);
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_err   = fetch_err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (RESET_PC=0, TIMEOUT=16).
module tb_instr_fetch_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    instr_fetch_if bus ();

    instr_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_word(input logic [15:0] data);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
    endtask

    task automatic exec(input logic done, input logic jmp, input logic [15:0] tgt, input logic hlt);
        bus.exec_done   = done;
        bus.jump        = jmp;
        bus.jump_target = tgt;
        bus.halt        = hlt;
        step();
        bus.exec_done   = 1'b0;
        bus.jump        = 1'b0;
        bus.jump_target = 16'h0000;
        bus.halt        = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.exec_done = 1'b0;
        bus.jump = 1'b0;
        bus.jump_target = 16'h0000;
        bus.halt = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_mem_req", 16'(bus.mem_req), 16'h0);
        chk("rst_pc", bus.pc, 16'h0000);
        chk("rst_instr", bus.instr, 16'h0000);
        chk("rst_valid", 16'(bus.instr_valid), 16'h0);
        chk("rst_halted", 16'(bus.halted), 16'h0);
        chk("rst_err", 16'(bus.fetch_err), 16'h0);
        rst = 1'b0;

        // First fetch and ack latency
        step();
        chk("first_req", 16'(bus.mem_req), 16'h1);
        chk("first_addr", bus.mem_addr, 16'h0000);
        ack_word(16'hE590);
        chk("first_instr", bus.instr, 16'hE590);
        chk("first_valid", 16'(bus.instr_valid), 16'h1);
        chk("first_req_drop", 16'(bus.mem_req), 16'h0);

        // Jump to 5 from a control word
        exec(1'b1, 1'b1, 16'h0005, 1'b0);
        chk("jmp5_req", 16'(bus.mem_req), 16'h1);
        chk("jmp5_addr", bus.mem_addr, 16'h0005);
        chk("jmp5_valid", 16'(bus.instr_valid), 16'h0);

        // Sequential step 5 -> 6
        ack_word(16'h0001);
        exec(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("seq6_addr", bus.mem_addr, 16'h0006);
        chk("seq6_req", 16'(bus.mem_req), 16'h1);

        // Wrap FFFF -> 0000
        ack_word(16'hE000);
        exec(1'b1, 1'b1, 16'hFFFF, 1'b0);
        chk("jmpffff_addr", bus.mem_addr, 16'hFFFF);
        ack_word(16'h1234);
        exec(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("wrap_addr", bus.mem_addr, 16'h0000);

        // Jump taken for bit15=1, ignored for bit15=0
        ack_word(16'hE762);
        exec(1'b1, 1'b1, 16'h002A, 1'b0);
        chk("jmp2a_addr", bus.mem_addr, 16'h002A);
        ack_word(16'h002A);
        exec(1'b1, 1'b1, 16'h1111, 1'b0);
        chk("nojmp_addr", bus.mem_addr, 16'h002B);

        // Memory stall of 10 cycles, then ack
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_req", 16'(bus.mem_req), 16'h1);
            chk("stall_addr", bus.mem_addr, 16'h002B);
            chk("stall_err", 16'(bus.fetch_err), 16'h0);
        end
        ack_word(16'hE000);
        chk("stall_valid", 16'(bus.instr_valid), 16'h1);
        chk("stall_instr", bus.instr, 16'hE000);

        // Halt handling: jump to 3, halt without done ignored, then halt with done
        exec(1'b1, 1'b1, 16'h0003, 1'b0);
        chk("jmp3_addr", bus.mem_addr, 16'h0003);
        ack_word(16'hE000);
        exec(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("halt_nodone_valid", 16'(bus.instr_valid), 16'h1);
        chk("halt_nodone_halted", 16'(bus.halted), 16'h0);
        chk("halt_nodone_pc", bus.pc, 16'h0003);
        exec(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("halt_pc", bus.pc, 16'h0004);
        chk("halt_halted", 16'(bus.halted), 16'h1);
        chk("halt_req", 16'(bus.mem_req), 16'h0);
        repeat (3) step();
        chk("halt_hold_req", 16'(bus.mem_req), 16'h0);
        chk("halt_hold_halted", 16'(bus.halted), 16'h1);
        chk("halt_hold_pc", bus.pc, 16'h0004);

        // Async reset out of HALTED, between edges
        #2 rst = 1'b1;
        #1;
        chk("areset_halted", 16'(bus.halted), 16'h0);
        chk("areset_pc", bus.pc, 16'h0000);
        rst = 1'b0;
        step();
        chk("restart_req", 16'(bus.mem_req), 16'h1);
        chk("restart_addr", bus.mem_addr, 16'h0000);

        // Async reset mid-FETCH
        step();
        #2 rst = 1'b1;
        #1;
        chk("mid_fetch_req", 16'(bus.mem_req), 16'h0);
        rst = 1'b0;
        step();
        chk("mid_fetch_restart", 16'(bus.mem_req), 16'h1);

        // Async reset mid-EXEC
        ack_word(16'hE590);
        chk("pre_exec_valid", 16'(bus.instr_valid), 16'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_exec_valid", 16'(bus.instr_valid), 16'h0);
        chk("mid_exec_instr", bus.instr, 16'h0000);
        rst = 1'b0;
        step();
        chk("mid_exec_restart_req", 16'(bus.mem_req), 16'h1);
        chk("mid_exec_restart_addr", bus.mem_addr, 16'h0000);

        // Timeout: 15 stalled cycles tolerated, 16th errors
        repeat (15) step();
        chk("to15_err", 16'(bus.fetch_err), 16'h0);
        chk("to15_req", 16'(bus.mem_req), 16'h1);
        step();
        chk("to16_err", 16'(bus.fetch_err), 16'h1);
        chk("to16_req", 16'(bus.mem_req), 16'h0);
        chk("to16_pc", bus.pc, 16'h0000);
        ack_word(16'hE590);
        chk("err_sticky", 16'(bus.fetch_err), 16'h1);
        chk("err_ignore_ack", 16'(bus.instr_valid), 16'h0);

        #2 rst = 1'b1;
        #1;
        chk("err_clear", 16'(bus.fetch_err), 16'h0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
